// File: rtl/gmux_quad_ctrl.sv
// Control-side sequencer for the four-quadrant GMUX: wake/drain/low-power per quadrant
// and a glitch-free SSEL change that only lands while every quadrant is off.
module gmux_quad_ctrl #(
  parameter int unsigned WAKE_CYC  = 4,
  parameter int unsigned DRAIN_CYC = 2,
  parameter int unsigned CNT_W     = 4,
  parameter logic        SSEL_RST  = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] REQ,
  input  logic [3:0] CFG_DYN,
  input  logic [3:0] GATE,
  input  logic       SEL_REQ,
  output logic [3:0] SEN,
  output logic [3:0] DEN,
  output logic [3:0] DYNEN,
  output logic [3:0] VLP,
  output logic [3:0] ACK,
  output logic       SSEL,
  output logic       SEL_PEND
);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_WAKE  = 2'd1,
    ST_ON    = 2'd2,
    ST_DRAIN = 2'd3
  } qstate_e;

  localparam logic [CNT_W-1:0] WAKE_LD  = CNT_W'(WAKE_CYC - 1);
  localparam logic [CNT_W-1:0] DRAIN_LD = CNT_W'(DRAIN_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  qstate_e          st_q  [4];
  qstate_e          st_d  [4];
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [3:0]       mode_q, mode_d;
  logic [3:0]       sen_q, sen_d;
  logic [3:0]       den_q, den_d;
  logic [3:0]       dynen_q, dynen_d;
  logic [3:0]       vlp_q, vlp_d;
  logic [3:0]       ack_q, ack_d;
  logic             ssel_q, ssel_d;
  logic             sel_pend_q, sel_pend_d;
  logic             all_off_s;

  // Per-quadrant next-state and counter logic; a pending select blocks new wakes.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      st_d[i]   = st_q[i];
      cnt_d[i]  = cnt_q[i];
      mode_d[i] = mode_q[i];
      case (st_q[i])
        ST_OFF: begin
          if (REQ[i] && !sel_pend_q) begin
            st_d[i]  = ST_WAKE;
            cnt_d[i] = WAKE_LD;
          end else begin
            st_d[i] = ST_OFF;
          end
        end
        ST_WAKE: begin
          if (!REQ[i]) begin
            st_d[i] = ST_OFF;
          end else if (cnt_q[i] == CNT_ZERO) begin
            st_d[i]   = ST_ON;
            mode_d[i] = CFG_DYN[i];
          end else begin
            cnt_d[i] = cnt_q[i] - CNT_ONE;
          end
        end
        ST_ON: begin
          if (!REQ[i]) begin
            st_d[i]  = ST_DRAIN;
            cnt_d[i] = DRAIN_LD;
          end else begin
            st_d[i] = ST_ON;
          end
        end
        ST_DRAIN: begin
          if (cnt_q[i] == CNT_ZERO) begin
            st_d[i] = ST_OFF;
          end else begin
            cnt_d[i] = cnt_q[i] - CNT_ONE;
          end
        end
        default: begin
          st_d[i] = ST_OFF;
        end
      endcase
    end
  end

  // Output decode from the next state so every output is a flop aligned with its state.
  always_comb begin
    sen_d   = 4'h0;
    den_d   = 4'h0;
    dynen_d = 4'h0;
    vlp_d   = 4'h0;
    ack_d   = 4'h0;
    for (int i = 0; i < 4; i++) begin
      case (st_d[i])
        ST_OFF: begin
          vlp_d[i] = 1'b1;
        end
        ST_ON: begin
          ack_d[i]   = 1'b1;
          sen_d[i]   = ~mode_d[i];
          dynen_d[i] = mode_d[i];
          den_d[i]   = mode_d[i] & GATE[i];
        end
        default: begin
          vlp_d[i] = 1'b0;
        end
      endcase
    end
  end

  // Select interlock: switch only when every quadrant currently sits in OFF.
  always_comb begin
    all_off_s  = (st_q[0] == ST_OFF) && (st_q[1] == ST_OFF) &&
                 (st_q[2] == ST_OFF) && (st_q[3] == ST_OFF);
    ssel_d     = ssel_q;
    sel_pend_d = sel_pend_q;
    if (sel_pend_q) begin
      if (SEL_REQ == ssel_q) begin
        sel_pend_d = 1'b0;
      end else if (all_off_s) begin
        ssel_d     = SEL_REQ;
        sel_pend_d = 1'b0;
      end else begin
        sel_pend_d = 1'b1;
      end
    end else begin
      sel_pend_d = (SEL_REQ != ssel_q);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 4; i++) begin
        st_q[i]  <= ST_OFF;
        cnt_q[i] <= CNT_ZERO;
      end
      mode_q     <= 4'h0;
      sen_q      <= 4'h0;
      den_q      <= 4'h0;
      dynen_q    <= 4'h0;
      vlp_q      <= 4'hF;
      ack_q      <= 4'h0;
      ssel_q     <= SSEL_RST;
      sel_pend_q <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      mode_q     <= mode_d;
      sen_q      <= sen_d;
      den_q      <= den_d;
      dynen_q    <= dynen_d;
      vlp_q      <= vlp_d;
      ack_q      <= ack_d;
      ssel_q     <= ssel_d;
      sel_pend_q <= sel_pend_d;
    end
  end

  assign SEN      = sen_q;
  assign DEN      = den_q;
  assign DYNEN    = dynen_q;
  assign VLP      = vlp_q;
  assign ACK      = ack_q;
  assign SSEL     = ssel_q;
  assign SEL_PEND = sel_pend_q;

endmodule

// File: tb/tb_gmux_quad_ctrl.sv
// Directed bench for gmux_quad_ctrl: a per-cycle vector table plus hand sequences
// for the select interlock and reset during drain.
module tb_gmux_quad_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] REQ, CFG_DYN, GATE;
  logic       SEL_REQ;
  logic [3:0] SEN, DEN, DYNEN, VLP, ACK;
  logic       SSEL, SEL_PEND;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rst;
    logic [3:0] req, cfg, gate;
    logic       sel;
    logic [3:0] sen, den, dyn, vlp, ack;
    logic       ssel, pend;
  } vec_t;

  vec_t vq[$];

  gmux_quad_ctrl #(
    .WAKE_CYC(4), .DRAIN_CYC(2), .CNT_W(4), .SSEL_RST(1'b1)
  ) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .CFG_DYN(CFG_DYN), .GATE(GATE),
    .SEL_REQ(SEL_REQ), .SEN(SEN), .DEN(DEN), .DYNEN(DYNEN), .VLP(VLP),
    .ACK(ACK), .SSEL(SSEL), .SEL_PEND(SEL_PEND)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic add(input logic rst, input logic [3:0] req, input logic [3:0] cfg,
                     input logic [3:0] gate, input logic sel,
                     input logic [3:0] sen, input logic [3:0] den, input logic [3:0] dyn,
                     input logic [3:0] vlp, input logic [3:0] ack,
                     input logic ssel, input logic pend);
    vec_t v;
    v.rst = rst; v.req = req; v.cfg = cfg; v.gate = gate; v.sel = sel;
    v.sen = sen; v.den = den; v.dyn = dyn; v.vlp = vlp; v.ack = ack;
    v.ssel = ssel; v.pend = pend;
    vq.push_back(v);
  endtask

  initial begin
    int n;
    RST = 1'b1; REQ = 4'h0; CFG_DYN = 4'h0; GATE = 4'h0; SEL_REQ = 1'b1;

    //   rst req   cfg   gate  sel   sen   den   dyn   vlp   ack   ssel  pend
    add(1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 1'b1, 1'b0);
    add(1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)
      add(1'b0, 4'hF, 4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
    add(1'b0, 4'hF, 4'h0, 4'h0, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF, 1'b1, 1'b0);
    add(1'b0, 4'hF, 4'hF, 4'hF, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF, 1'b1, 1'b0);
    add(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
    add(1'b0, 4'hF, 4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
    add(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 1'b1, 1'b0);
    // dynamic quadrant 2
    for (int i = 0; i < 4; i++)
      add(1'b0, 4'h4, 4'h4, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'hB, 4'h0, 1'b1, 1'b0);
    add(1'b0, 4'h4, 4'h4, 4'h0, 1'b1, 4'h0, 4'h0, 4'h4, 4'hB, 4'h4, 1'b1, 1'b0);
    add(1'b0, 4'h4, 4'h0, 4'h4, 1'b1, 4'h0, 4'h4, 4'h4, 4'hB, 4'h4, 1'b1, 1'b0);
    add(1'b0, 4'h4, 4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 4'h4, 4'hB, 4'h4, 1'b1, 1'b0);
    add(1'b0, 4'h4, 4'h0, 4'h4, 1'b1, 4'h0, 4'h4, 4'h4, 4'hB, 4'h4, 1'b1, 1'b0);
    add(1'b0, 4'h0, 4'h0, 4'h4, 1'b1, 4'h0, 4'h0, 4'h0, 4'hB, 4'h0, 1'b1, 1'b0);
    add(1'b0, 4'h0, 4'h0, 4'h4, 1'b1, 4'h0, 4'h0, 4'h0, 4'hB, 4'h0, 1'b1, 1'b0);
    add(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 1'b1, 1'b0);
    // wake abort on quadrant 0
    add(1'b0, 4'h1, 4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'hE, 4'h0, 1'b1, 1'b0);
    add(1'b0, 4'h1, 4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'hE, 4'h0, 1'b1, 1'b0);
    add(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 1'b1, 1'b0);
    add(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 1'b1, 1'b0);
    // select change with all quadrants off, then a cancelled request
    add(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 1'b1, 1'b1);
    add(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 1'b0, 1'b0);
    add(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 1'b0, 1'b0);
    add(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 1'b0, 1'b1);
    add(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 1'b0, 1'b0);
    // select request alongside a wake: the waking quadrant is not forced off
    add(1'b0, 4'h1, 4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'hE, 4'h0, 1'b0, 1'b1);
    add(1'b0, 4'h1, 4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'hE, 4'h0, 1'b0, 1'b1);
    add(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 1'b0, 1'b1);
    add(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 1'b1, 1'b0);

    foreach (vq[k]) begin
      RST = vq[k].rst; REQ = vq[k].req; CFG_DYN = vq[k].cfg;
      GATE = vq[k].gate; SEL_REQ = vq[k].sel;
      step();
      chk($sformatf("v%0d.sen", k),   SEN,      vq[k].sen);
      chk($sformatf("v%0d.den", k),   DEN,      vq[k].den);
      chk($sformatf("v%0d.dynen", k), DYNEN,    vq[k].dyn);
      chk($sformatf("v%0d.vlp", k),   VLP,      vq[k].vlp);
      chk($sformatf("v%0d.ack", k),   ACK,      vq[k].ack);
      chk($sformatf("v%0d.ssel", k),  SSEL,     vq[k].ssel);
      chk($sformatf("v%0d.pend", k),  SEL_PEND, vq[k].pend);
    end

    // Interlock: quadrant 1 live, select change waits for drain, quadrant 3 held off.
    REQ = 4'h2; CFG_DYN = 4'h0; GATE = 4'h0; SEL_REQ = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (ACK[1] !== 1'b1 && n < 20);
    chk("q1_wake_latency", 8'(n), 8'd5);
    chk("q1_sen", SEN, 4'h2);
    SEL_REQ = 1'b0;
    step();
    chk("il_pend_set", SEL_PEND, 1'b1);
    chk("il_ssel_hold", SSEL, 1'b1);
    REQ = 4'hA;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("il_q3_held_vlp", VLP, 4'hD);
      chk("il_q1_ack", ACK, 4'h2);
    end
    REQ = 4'h8;
    step();
    chk("il_drain_ack", ACK, 4'h0);
    chk("il_drain_vlp", VLP, 4'hD);
    step();
    chk("il_drain2_vlp", VLP, 4'hD);
    step();
    chk("il_off_vlp", VLP, 4'hF);
    chk("il_off_ssel", SSEL, 1'b1);
    chk("il_off_pend", SEL_PEND, 1'b1);
    step();
    chk("il_sw_ssel", SSEL, 1'b0);
    chk("il_sw_pend", SEL_PEND, 1'b0);
    chk("il_sw_vlp", VLP, 4'hF);
    step();
    chk("il_q3_wake_vlp", VLP, 4'h7);
    for (int i = 0; i < 4; i++) step();
    chk("il_q3_ack", ACK, 4'h8);
    chk("il_q3_sen", SEN, 4'h8);

    // Reset on the second DRAIN cycle of quadrant 3.
    REQ = 4'h0;
    step();
    chk("rd_drain1_ack", ACK, 4'h0);
    step();
    chk("rd_drain2_vlp", VLP, 4'h7);
    RST = 1'b1; SEL_REQ = 1'b1;
    step();
    chk("rd_vlp", VLP, 4'hF);
    chk("rd_ack", ACK, 4'h0);
    chk("rd_sen", SEN, 4'h0);
    chk("rd_ssel", SSEL, 1'b1);
    chk("rd_pend", SEL_PEND, 1'b0);
    RST = 1'b0;
    step();
    chk("rd_after_vlp", VLP, 4'hF);
    chk("rd_after_ack", ACK, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
